// File: rtl/hero_write_arb.sv
// hero_write_arb
// ---------------------------------------------------------------------------
// Merges NUM_CH hero write sources onto a single hero write bus. Each channel
// buffers its beats {cycle_type, wdat, clk_en} in a small FIFO. A round-robin
// arbiter grants whole transactions: once a VALID beat has been taken from a
// channel, that channel keeps the bus until its DONE beat is taken.
//
// cycle_type encoding: IDLE=0, VALID=1, DONE=2, 3=reserved (dropped on input).
//
// Handshake (both sides): a beat transfers in a cycle where it is offered
// (cycle_type != IDLE) and the receiver's ready is 1. On the input side the
// source must only offer while in_ready[c]=1; an offer while in_ready[c]=0 is
// lost. On the output side a beat offered while out_ready=0 stays on out_*
// unchanged until it is taken.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   in_cycle_type    per-channel cycle_type, channel c at [2c+1:2c]
//   in_wdat          per-channel write data, channel c at [DATA_W*c +: DATA_W]
//   in_clk_en        per-channel clk_en
//   in_ready         per-channel FIFO not full
//   out_cycle_type   merged cycle_type (IDLE when nothing is granted)
//   out_wdat         merged write data (0 when nothing is granted)
//   out_clk_en       merged clk_en (0 when nothing is granted)
//   out_ch_id        source channel of the current beat (holds when idle)
//   out_ready        downstream accepts the current beat
//   txn_cnt          count of DONE beats taken, wraps at 16 bits
//   err_timeout      sticky starvation watchdog flag
//
// Optional feature: define HERO_WRITE_ARB_TIMEOUT_EN to enable the lock
// watchdog. Without it err_timeout is 0 and a lock is held indefinitely.
// ---------------------------------------------------------------------------
module hero_write_arb #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 36,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2*NUM_CH-1:0]         in_cycle_type,
    input  logic [DATA_W*NUM_CH-1:0]    in_wdat,
    input  logic [NUM_CH-1:0]           in_clk_en,
    output logic [NUM_CH-1:0]           in_ready,
    output logic [1:0]                  out_cycle_type,
    output logic [DATA_W-1:0]           out_wdat,
    output logic                        out_clk_en,
    output logic [$clog2(NUM_CH)-1:0]   out_ch_id,
    input  logic                        out_ready,
    output logic [15:0]                 txn_cnt,
    output logic                        err_timeout
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int BEAT_W = 2 + DATA_W + 1;

    localparam logic [1:0] CT_IDLE  = 2'd0;
    localparam logic [1:0] CT_VALID = 2'd1;
    localparam logic [1:0] CT_DONE  = 2'd2;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_LOCK = 1'b1;

    // Arbiter state, kept as plain named signals so checkers can bind to them.
    logic [0:0]             state;
    logic [CH_W-1:0]        rr_ptr;
    logic [CH_W-1:0]        sel_ch;    // locked channel, or grant held across a stall
    logic                   hold;      // ARB_IDLE grant is stalled on sel_ch
    logic [CH_W-1:0]        ch_id_q;
    logic [15:0]            txn_q;

    logic [NUM_CH-1:0]              empty;
    logic [NUM_CH-1:0]              full;
    logic [NUM_CH-1:0]              pop;
    logic [NUM_CH-1:0][BEAT_W-1:0]  head;

    logic                   gnt_valid;
    logic [CH_W-1:0]        gnt_ch;
    logic [BEAT_W-1:0]      gnt_beat;
    logic                   pop_any;
    logic                   pop_done;
    logic [CH_W-1:0]        next_rr;
    logic                   timeout_hit;

    // ------------------------------------------------------------------
    // Per-channel FIFOs. Pointers carry one extra wrap bit so full and
    // empty are distinguishable. in_ready depends only on registered
    // occupancy: a pop in the same cycle never frees room for a push.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [BEAT_W-1:0] mem [FIFO_DEPTH];
        logic [AW:0]       wr_ptr;
        logic [AW:0]       rd_ptr;
        logic [1:0]        ct;
        logic              push;

        assign ct       = in_cycle_type[2*c +: 2];
        assign empty[c] = (wr_ptr == rd_ptr);
        assign full[c]  = (wr_ptr[AW] != rd_ptr[AW]) &&
                          (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign in_ready[c] = ~full[c];
        // IDLE and the reserved code 3 are never stored.
        assign push     = ~full[c] && (ct == CT_VALID || ct == CT_DONE);
        assign head[c]  = mem[rd_ptr[AW-1:0]];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[c]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {ct, in_wdat[DATA_W*c +: DATA_W], in_clk_en[c]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant selection.
    // ------------------------------------------------------------------
    always_comb begin
        logic            rr_found;
        logic [CH_W-1:0] rr_win;
        rr_found = 1'b0;
        rr_win   = '0;
        // First non-empty channel at or after rr_ptr, wrapping to 0.
        for (int i = 0; i < NUM_CH; i++) begin
            int idx;
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!rr_found && !empty[idx]) begin
                rr_found = 1'b1;
                rr_win   = CH_W'(idx);
            end
        end

        if (state == ARB_LOCK) begin
            // Only the locked channel may drive the bus; empty means a bubble.
            gnt_ch    = sel_ch;
            gnt_valid = ~empty[sel_ch];
        end else if (hold) begin
            // A stalled beat keeps its grant so out_* stays stable.
            gnt_ch    = sel_ch;
            gnt_valid = ~empty[sel_ch];
        end else begin
            gnt_ch    = rr_win;
            gnt_valid = rr_found;
        end
    end

    assign gnt_beat = head[gnt_ch];
    assign pop_any  = gnt_valid && out_ready;
    assign pop_done = pop_any && (gnt_beat[BEAT_W-1 -: 2] == CT_DONE);
    assign next_rr  = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;

    always_comb begin
        pop = '0;
        pop[gnt_ch] = pop_any;
    end

    assign out_cycle_type = gnt_valid ? gnt_beat[BEAT_W-1 -: 2] : CT_IDLE;
    assign out_wdat       = gnt_valid ? gnt_beat[DATA_W:1]      : '0;
    assign out_clk_en     = gnt_valid ? gnt_beat[0]             : 1'b0;
    assign out_ch_id      = gnt_valid ? gnt_ch                  : ch_id_q;
    assign txn_cnt        = txn_q;

    // ------------------------------------------------------------------
    // Arbiter FSM.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            sel_ch  <= '0;
            hold    <= 1'b0;
            ch_id_q <= '0;
            txn_q   <= '0;
        end else begin
            if (gnt_valid) begin
                ch_id_q <= gnt_ch;
            end

            if (pop_any) begin
                hold <= 1'b0;
                if (pop_done) begin
                    // Completing channel drops to lowest priority.
                    state  <= ARB_IDLE;
                    rr_ptr <= next_rr;
                    txn_q  <= txn_q + 16'd1;
                end else begin
                    state  <= ARB_LOCK;
                    sel_ch <= gnt_ch;
                end
            end else if (state == ARB_IDLE && gnt_valid) begin
                hold   <= 1'b1;
                sel_ch <= gnt_ch;
            end else if (timeout_hit) begin
                // Forced release: the abandoned channel still loses priority.
                state  <= ARB_IDLE;
                rr_ptr <= next_rr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock watchdog.
    // ------------------------------------------------------------------
`ifdef HERO_WRITE_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        err_q;

    assign timeout_hit = (state == ARB_LOCK) && !gnt_valid &&
                         ((to_cnt + 16'd1) == 16'(TIMEOUT_CYC));
    assign err_timeout = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != ARB_LOCK || pop_any || timeout_hit) begin
                to_cnt <= '0;
            end else if (!gnt_valid) begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hero_write_arb.sv
// Testbench for hero_write_arb (default parameters: 4 channels, 36-bit data,
// 4-deep FIFOs, watchdog limit 64). Directed vector table, round-robin soak
// with txn_cnt wrap, randomized traffic against a queue-based reference
// model, and the lock watchdog scenario.
module tb_hero_write_arb;

    localparam int NUM_CH      = 4;
    localparam int DATA_W      = 36;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int RR_CYC      = 65536;

    // ---------------- clock / reset / DUT ----------------
    logic                       clk;
    logic                       rst_n;
    logic [2*NUM_CH-1:0]        in_cycle_type;
    logic [DATA_W*NUM_CH-1:0]   in_wdat;
    logic [NUM_CH-1:0]          in_clk_en;
    logic [NUM_CH-1:0]          in_ready;
    logic [1:0]                 out_cycle_type;
    logic [DATA_W-1:0]          out_wdat;
    logic                       out_clk_en;
    logic [1:0]                 out_ch_id;
    logic                       out_ready;
    logic [15:0]                txn_cnt;
    logic                       err_timeout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hero_write_arb #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_cycle_type(in_cycle_type), .in_wdat(in_wdat), .in_clk_en(in_clk_en),
        .in_ready(in_ready),
        .out_cycle_type(out_cycle_type), .out_wdat(out_wdat), .out_clk_en(out_clk_en),
        .out_ch_id(out_ch_id), .out_ready(out_ready),
        .txn_cnt(txn_cnt), .err_timeout(err_timeout)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is a queue of pending beats; the bus owner is either the
    // channel inside an open transaction, the channel whose beat is stalled,
    // or the first waiting channel after the last one to finish.
    typedef struct {
        logic [1:0]        t;
        logic [DATA_W-1:0] d;
        logic              ce;
    } beat_t;

    beat_t       exp_q[NUM_CH][$];
    bit          m_in_txn;
    bit          m_stalled;
    int          m_owner;
    int          m_next_first;
    int          m_last_id;
    logic [15:0] m_txn;
    bit          m_err;
    int          m_empty_cyc;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
        m_in_txn = 0; m_stalled = 0; m_owner = 0; m_next_first = 0;
        m_last_id = 0; m_txn = 16'd0; m_err = 0; m_empty_cyc = 0;
    endtask

    task automatic model_present(output bit v, output int src);
        v = 0;
        src = 0;
        if (m_in_txn) begin
            src = m_owner;
            v = (exp_q[m_owner].size() != 0);
        end else if (m_stalled) begin
            src = m_owner;
            v = 1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                int c;
                c = (m_next_first + i) % NUM_CH;
                if (!v && exp_q[c].size() != 0) begin
                    v = 1;
                    src = c;
                end
            end
        end
    endtask

    task automatic model_check();
        bit                v;
        int                src;
        logic [NUM_CH-1:0] e_rdy;
        beat_t             h;
        model_present(v, src);
        for (int c = 0; c < NUM_CH; c++) e_rdy[c] = (exp_q[c].size() < FIFO_DEPTH);
        if (v) h = exp_q[src][0];
        else begin
            h.t = 2'd0; h.d = '0; h.ce = 1'b0;
        end
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
        chk("out_cycle_type", 64'(out_cycle_type), 64'(h.t));
        chk("out_wdat", 64'(out_wdat), 64'(h.d));
        chk("out_clk_en", 64'(out_clk_en), 64'(h.ce));
        chk("out_ch_id", 64'(out_ch_id), 64'(v ? src : m_last_id));
        chk("txn_cnt", 64'(txn_cnt), 64'(m_txn));
        chk("err_timeout", 64'(err_timeout), 64'(m_err));
    endtask

    task automatic model_step();
        bit    v;
        int    src;
        int    sz[NUM_CH];
        beat_t h;
        if (!rst_n) begin
            model_reset();
            return;
        end
        model_present(v, src);
        for (int c = 0; c < NUM_CH; c++) sz[c] = exp_q[c].size();
        if (v) m_last_id = src;
        if (v && out_ready) begin
            h = exp_q[src].pop_front();
            m_empty_cyc = 0;
            m_stalled = 0;
            if (h.t == 2'd2) begin
                m_in_txn = 0;
                m_next_first = (src + 1) % NUM_CH;
                m_txn = m_txn + 16'd1;
            end else begin
                m_in_txn = 1;
                m_owner = src;
            end
        end else if (v && !m_in_txn) begin
            m_stalled = 1;
            m_owner = src;
        end else if (m_in_txn && !v) begin
`ifdef HERO_WRITE_ARB_TIMEOUT_EN
            m_empty_cyc++;
            if (m_empty_cyc == TIMEOUT_CYC) begin
                m_err = 1;
                m_in_txn = 0;
                m_next_first = (m_owner + 1) % NUM_CH;
                m_empty_cyc = 0;
            end
`endif
        end
        for (int c = 0; c < NUM_CH; c++) begin
            logic [1:0] t;
            t = in_cycle_type[2*c +: 2];
            if ((t == 2'd1 || t == 2'd2) && sz[c] < FIFO_DEPTH) begin
                h.t = t;
                h.d = in_wdat[DATA_W*c +: DATA_W];
                h.ce = in_clk_en[c];
                exp_q[c].push_back(h);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        finish_cycle();
    endtask

    task automatic drive_idle();
        in_cycle_type = '0;
        in_wdat = '0;
        in_clk_en = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        finish_cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  ct;
        logic [35:0] wa;     // data on channels 0 and 2
        logic [35:0] wb;     // data on channels 1 and 3
        logic [3:0]  ce;
        logic        orr;
        logic [3:0]  e_rdy;
        logic [1:0]  e_t;
        logic [35:0] e_d;
        logic        e_ce;
        logic [1:0]  e_id;
        logic [15:0] e_txn;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic [7:0] ct, logic [35:0] wa, logic [35:0] wb,
                                logic [3:0] ce, logic orr, logic [3:0] e_rdy,
                                logic [1:0] e_t, logic [35:0] e_d, logic e_ce,
                                logic [1:0] e_id, logic [15:0] e_txn);
        vec_t r;
        r.ct = ct; r.wa = wa; r.wb = wb; r.ce = ce; r.orr = orr;
        r.e_rdy = e_rdy; r.e_t = e_t; r.e_d = e_d; r.e_ce = e_ce;
        r.e_id = e_id; r.e_txn = e_txn;
        return r;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        bit found;
        int k_found;

        rst_n = 1'b0;
        in_cycle_type = {NUM_CH{2'd1}};
        in_wdat = '1;
        in_clk_en = '1;
        out_ready = 1'b1;
        model_reset();

        // Reset with VALID on all inputs: nothing may be stored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            finish_cycle();
        end
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'hF);
        chk("rst_out_type", 64'(out_cycle_type), 64'd0);
        chk("rst_txn_cnt", 64'(txn_cnt), 64'd0);
        model_check();
        finish_cycle();
        rst_n = 1'b1;
        drive_idle();
        cycle();
        @(negedge clk);
        chk("rst_no_beats", 64'(out_cycle_type), 64'd0);
        model_check();
        finish_cycle();

        // Single beat, atomicity, backpressure.
        tbl[0]  = mk(8'h20, 36'h123456789, 36'd0, 4'hF, 1, 4'hF, 0, 36'd0, 0, 0, 0);
        tbl[1]  = mk(8'h00, 36'd0, 36'd0, 4'h0, 1, 4'hF, 2, 36'h123456789, 1, 2, 0);
        tbl[2]  = mk(8'h00, 36'd0, 36'd0, 4'h0, 1, 4'hF, 0, 36'd0, 0, 2, 1);
        tbl[3]  = mk(8'h09, 36'd1, 36'd9, 4'h2, 1, 4'hF, 0, 36'd0, 0, 2, 1);
        tbl[4]  = mk(8'h01, 36'd2, 36'd0, 4'h1, 1, 4'hF, 1, 36'd1, 0, 0, 1);
        tbl[5]  = mk(8'h02, 36'd3, 36'd0, 4'h0, 1, 4'hF, 1, 36'd2, 1, 0, 1);
        tbl[6]  = mk(8'h00, 36'd0, 36'd0, 4'h0, 1, 4'hF, 2, 36'd3, 0, 0, 1);
        tbl[7]  = mk(8'h00, 36'd0, 36'd0, 4'h0, 1, 4'hF, 2, 36'd9, 1, 1, 2);
        tbl[8]  = mk(8'h00, 36'd0, 36'd0, 4'h0, 1, 4'hF, 0, 36'd0, 0, 1, 3);
        tbl[9]  = mk(8'h40, 36'd0, 36'd10, 4'h8, 0, 4'hF, 0, 36'd0, 0, 1, 3);
        tbl[10] = mk(8'h40, 36'd0, 36'd11, 4'h0, 0, 4'hF, 1, 36'd10, 1, 3, 3);
        tbl[11] = mk(8'h40, 36'd0, 36'd12, 4'h0, 0, 4'hF, 1, 36'd10, 1, 3, 3);
        tbl[12] = mk(8'h40, 36'd0, 36'd13, 4'h0, 0, 4'hF, 1, 36'd10, 1, 3, 3);
        tbl[13] = mk(8'h40, 36'd0, 36'd14, 4'h0, 0, 4'h7, 1, 36'd10, 1, 3, 3);
        tbl[14] = mk(8'h00, 36'd0, 36'd0, 4'h0, 1, 4'h7, 1, 36'd10, 1, 3, 3);
        tbl[15] = mk(8'h00, 36'd0, 36'd0, 4'h0, 1, 4'hF, 1, 36'd11, 0, 3, 3);
        tbl[16] = mk(8'h00, 36'd0, 36'd0, 4'h0, 1, 4'hF, 1, 36'd12, 0, 3, 3);
        tbl[17] = mk(8'h00, 36'd0, 36'd0, 4'h0, 1, 4'hF, 1, 36'd13, 0, 3, 3);
        tbl[18] = mk(8'h80, 36'd0, 36'd15, 4'h8, 1, 4'hF, 0, 36'd0, 0, 3, 3);
        tbl[19] = mk(8'h00, 36'd0, 36'd0, 4'h0, 1, 4'hF, 2, 36'd15, 1, 3, 3);
        tbl[20] = mk(8'h00, 36'd0, 36'd0, 4'h0, 1, 4'hF, 0, 36'd0, 0, 3, 4);

        for (int r = 0; r < 21; r++) begin
            in_cycle_type = tbl[r].ct;
            in_wdat = {tbl[r].wb, tbl[r].wa, tbl[r].wb, tbl[r].wa};
            in_clk_en = tbl[r].ce;
            out_ready = tbl[r].orr;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", r), 64'(in_ready), 64'(tbl[r].e_rdy));
            chk($sformatf("vec%0d_type", r), 64'(out_cycle_type), 64'(tbl[r].e_t));
            chk($sformatf("vec%0d_wdat", r), 64'(out_wdat), 64'(tbl[r].e_d));
            chk($sformatf("vec%0d_clk_en", r), 64'(out_clk_en), 64'(tbl[r].e_ce));
            chk($sformatf("vec%0d_ch_id", r), 64'(out_ch_id), 64'(tbl[r].e_id));
            chk($sformatf("vec%0d_txn", r), 64'(txn_cnt), 64'(tbl[r].e_txn));
            model_check();
            finish_cycle();
        end

        // Continuous single-beat DONE traffic on every channel.
        for (int i = 0; i < RR_CYC; i++) begin
            in_cycle_type = {NUM_CH{2'd2}};
            for (int c = 0; c < NUM_CH; c++) in_wdat[DATA_W*c +: DATA_W] = DATA_W'(i * 4 + c);
            in_clk_en = 4'($urandom_range(0, 15));
            out_ready = 1'b1;
            @(negedge clk);
            if (i >= 1 && i <= 12) begin
                chk("rr_ch_id", 64'(out_ch_id), 64'((i - 1) % NUM_CH));
                chk("rr_type", 64'(out_cycle_type), 64'd2);
            end
            model_check();
            finish_cycle();
        end
        drive_idle();
        @(negedge clk);
        chk("rr_txn_wrap", 64'(txn_cnt), 64'((4 + RR_CYC - 1) % 65536));
        model_check();
        finish_cycle();
        for (int i = 0; i < 20; i++) cycle();

        // Randomized traffic, including reserved codes, ready violations and
        // one reset in the middle of traffic.
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                in_cycle_type[2*c +: 2] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
                in_wdat[DATA_W*c +: DATA_W] = DATA_W'({$urandom(), $urandom()});
                in_clk_en[c] = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n = (i != 2000);
            cycle();
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive_idle();
        for (int i = 0; i < 20; i++) cycle();

        // Lock starvation: ch1 opens a transaction and goes silent, ch2 waits.
        do_reset();
        in_cycle_type = 8'h24;
        in_wdat = '0;
        out_ready = 1'b1;
        cycle();
        drive_idle();
        found = 0;
        k_found = 0;
`ifdef HERO_WRITE_ARB_TIMEOUT_EN
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (!found && out_cycle_type == 2'd2 && out_ch_id == 2'd2) begin
                found = 1;
                k_found = k;
                chk("timeout_err_set", 64'(err_timeout), 64'd1);
            end
            model_check();
            finish_cycle();
        end
        chk("timeout_ch2_granted", 64'(found), 64'd1);
        chk("timeout_grant_cycle", 64'(k_found), 64'd66);
`else
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            chk("lock_held_ch2_starved", 64'(out_cycle_type != 2'd0 && out_ch_id == 2'd2), 64'd0);
            model_check();
            finish_cycle();
        end
`endif
        do_reset();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
